// File: rtl/mmio_io_responder.sv
// MMIO responder between processor and RAM: sticky button press flags, VGA output
// handshake and 1-cycle read mux. Optional button event FIFO via MMIO_EVENT_FIFO_EN.
module mmio_io_responder #(
    parameter logic [31:0] ADDR_BTNC  = 32'd1000,
    parameter logic [31:0] ADDR_OUT   = 32'd2000,
    parameter logic [31:0] ADDR_BTNL  = 32'd3000,
    parameter logic [31:0] ADDR_BTNR  = 32'd4000,
    parameter logic [31:0] ADDR_BTNU  = 32'd5000,
`ifdef MMIO_EVENT_FIFO_EN
    parameter logic [31:0] ADDR_FIFO  = 32'd7000,
    parameter int          FIFO_DEPTH = 4,
`endif
    parameter logic [31:0] ADDR_BTND  = 32'd6000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic [31:0] ram_q,
    output logic        ram_wren,
    output logic [31:0] q_dmem,
    input  logic [4:0]  btn,
    output logic [31:0] vga_data,
    output logic        vga_valid,
    input  logic        vga_ready
);

    logic [4:0]  btn_sel;
    logic        hit_out;
    logic        hit_fifo;
    logic        io_hit;
    logic        rd_out;
    logic        wr_out;
    logic        slot_free;
    logic [4:0]  rise;

    logic [4:0]  btn_prev_q;
    logic [4:0]  pend_q, pend_d;
    logic        overrun_q, overrun_d;
    logic        vga_valid_q, vga_valid_d;
    logic [31:0] vga_data_q, vga_data_d;
    logic        sel_q;
    logic [31:0] io_q, io_d;

    assign btn_sel = {address_dmem == ADDR_BTND, address_dmem == ADDR_BTNU,
                      address_dmem == ADDR_BTNR, address_dmem == ADDR_BTNL,
                      address_dmem == ADDR_BTNC};
    assign hit_out = (address_dmem == ADDR_OUT);
`ifdef MMIO_EVENT_FIFO_EN
    assign hit_fifo = (address_dmem == ADDR_FIFO);
`else
    assign hit_fifo = 1'b0;
`endif
    assign io_hit    = (|btn_sel) | hit_out | hit_fifo;
    assign ram_wren  = wren & ~io_hit;
    assign rd_out    = hit_out & ~wren;
    assign wr_out    = hit_out & wren;
    assign slot_free = ~vga_valid_q | vga_ready;
    assign rise      = btn & ~btn_prev_q;

`ifdef MMIO_EVENT_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = hit_fifo & ~wren & ~fifo_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = (|rise) & (~fifo_full | pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem_q[wr_ptr_q] <= rise;
    end
`endif

    always_comb begin
        pend_d      = (pend_q & ~(btn_sel & {5{~wren}})) | rise;
        overrun_d   = (overrun_q & ~rd_out) | (wr_out & ~slot_free);
        vga_valid_d = vga_valid_q;
        vga_data_d  = vga_data_q;
        if (wr_out && slot_free) begin
            vga_valid_d = 1'b1;
            vga_data_d  = data;
        end else if (vga_valid_q && vga_ready) begin
            vga_valid_d = 1'b0;
        end

        io_d = '0;
        if (hit_out)
            io_d = {30'b0, vga_valid_q, overrun_q};
        else if (|btn_sel)
            io_d = {31'b0, |(pend_q & btn_sel)};
`ifdef MMIO_EVENT_FIFO_EN
        else if (hit_fifo && !fifo_empty)
            io_d = {1'b1, 26'b0, fifo_mem_q[rd_ptr_q]};
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_prev_q  <= 5'b11111;
            pend_q      <= '0;
            overrun_q   <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
            sel_q       <= 1'b0;
            io_q        <= '0;
        end else begin
            btn_prev_q  <= btn;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            vga_valid_q <= vga_valid_d;
            vga_data_q  <= vga_data_d;
            sel_q       <= io_hit & ~wren;
            io_q        <= io_d;
        end
    end

    assign q_dmem    = sel_q ? io_q : ram_q;
    assign vga_data  = vga_data_q;
    assign vga_valid = vga_valid_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder; FIFO section follows MMIO_EVENT_FIFO_EN.
module tb_mmio_io_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] ram_q;
    logic        ram_wren;
    logic [31:0] q_dmem;
    logic [4:0]  btn;
    logic [31:0] vga_data;
    logic        vga_valid;
    logic        vga_ready;

    int n_vec = 0;
    int n_err = 0;

    mmio_io_responder dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .address_dmem (address_dmem),
        .data         (data),
        .ram_q        (ram_q),
        .ram_wren     (ram_wren),
        .q_dmem       (q_dmem),
        .btn          (btn),
        .vga_data     (vga_data),
        .vga_valid    (vga_valid),
        .vga_ready    (vga_ready)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        wren = 1'b0;
        address_dmem = a;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wren = 1'b1;
        address_dmem = a;
        data = d;
        step();
    endtask

    initial begin
        reset = 1'b1; wren = 1'b0; address_dmem = 32'd100; data = '0;
        ram_q = 32'hCAFE_0000; btn = 5'b00100; vga_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", {31'b0, vga_valid}, 32'd0);
        check("rst_data", vga_data, 32'd0);
        check("rst_q", q_dmem, 32'hCAFE_0000);
        check("rst_ramwren", {31'b0, ram_wren}, 32'd0);
        reset = 1'b0;

        // held-through-reset button gives no press
        rd(32'd4000);  check("btnr_held", q_dmem, 32'd0);
        address_dmem = 32'd100;
        btn = 5'b00000; step();
        btn = 5'b00100; step();
        rd(32'd4000);  check("btnr_press", q_dmem, 32'd1);
        rd(32'd4000);  check("btnr_clear", q_dmem, 32'd0);

        // rise coincident with read: read sees old flag, flag stays set
        btn = 5'b00110;
        rd(32'd3000);  check("btnl_coinc", q_dmem, 32'd0);
        rd(32'd3000);  check("btnl_kept", q_dmem, 32'd1);
        rd(32'd3000);  check("btnl_clear", q_dmem, 32'd0);

        // output handshake and overrun
        wren = 1'b1; address_dmem = 32'd2000; data = 32'h1234; #1;
        check("out_ramwren", {31'b0, ram_wren}, 32'd0);
        step();
        check("out_valid", {31'b0, vga_valid}, 32'd1);
        check("out_data", vga_data, 32'h1234);
        wr(32'd2000, 32'h5678);
        check("drop_data", vga_data, 32'h1234);
        check("drop_valid", {31'b0, vga_valid}, 32'd1);
        rd(32'd2000);  check("stat_ovr", q_dmem, 32'd3);
        vga_ready = 1'b1;
        rd(32'd100);   check("consume", {31'b0, vga_valid}, 32'd0);
        vga_ready = 1'b0;
        rd(32'd2000);  check("stat_idle", q_dmem, 32'd0);

        // write accepted in the same cycle the old word is consumed
        wr(32'd2000, 32'h11);
        vga_ready = 1'b1;
        wr(32'd2000, 32'hAA);
        check("pass_data", vga_data, 32'hAA);
        check("pass_valid", {31'b0, vga_valid}, 32'd1);
        vga_ready = 1'b0;
        rd(32'd2000);  check("pass_stat", q_dmem, 32'd2);
        vga_ready = 1'b1;
        rd(32'd100);
        vga_ready = 1'b0;

        // plain RAM access
        wren = 1'b1; address_dmem = 32'd12; data = 32'hDEAD; #1;
        check("ram_wr", {31'b0, ram_wren}, 32'd1);
        step();
        ram_q = 32'h0000_BEEF;
        rd(32'd12);    check("ram_rd", q_dmem, 32'h0000_BEEF);
        ram_q = 32'h0000_1111; #1;
        check("ram_mux", q_dmem, 32'h0000_1111);

        // remaining buttons; writes to a button address are ignored
        btn = 5'b00000; rd(32'd100);
        btn = 5'b11001; rd(32'd100);
        wren = 1'b1; address_dmem = 32'd1000; #1;
        check("btn_wr_ram", {31'b0, ram_wren}, 32'd0);
        step();
        rd(32'd1000);  check("btnc", q_dmem, 32'd1);
        rd(32'd5000);  check("btnu", q_dmem, 32'd1);
        rd(32'd6000);  check("btnd", q_dmem, 32'd1);
        rd(32'd3000);  check("btnl_none", q_dmem, 32'd0);

        // reset mid-operation
        wr(32'd2000, 32'h77);
        ram_q = 32'h0000_3333;
        rd(32'd2000);
        #2 reset = 1'b1; #1;
        check("mid_valid", {31'b0, vga_valid}, 32'd0);
        check("mid_data", vga_data, 32'd0);
        check("mid_q", q_dmem, 32'h0000_3333);
        step();
        reset = 1'b0;
        rd(32'd1000);  check("btnc_held", q_dmem, 32'd0);

`ifdef MMIO_EVENT_FIFO_EN
        btn = 5'b00000; rd(32'd100);
        for (int i = 0; i < 5; i++) begin
            btn = 5'b00001; rd(32'd100);
            btn = 5'b00000; rd(32'd100);
        end
        for (int i = 0; i < 4; i++) begin
            rd(32'd7000); check("fifo_pop", q_dmem, 32'h8000_0001);
        end
        rd(32'd7000);  check("fifo_empty", q_dmem, 32'd0);
`else
        ram_q = 32'h5A5A_5A5A;
        rd(32'd7000);  check("fifo_ram_rd", q_dmem, 32'h5A5A_5A5A);
        wren = 1'b1; address_dmem = 32'd7000; #1;
        check("fifo_ram_wr", {31'b0, ram_wren}, 32'd1);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
